// File: rtl/modulo_controlador_jogo.sv
// modulo_controlador_jogo: phase sequencer for the 7x5 LED-matrix naval-battle game.
// Runs idle -> positioning -> attack/resolve -> game over, moves the cursor,
// strobes the position/attack register matrices and keeps the shot/hit counters.
// Optional build macro MODULO_CONTROLADOR_DEBOUNCE_EN inserts a stability-counter
// debouncer after each button synchronizer; without it the buttons are assumed
// to be debounced externally.
module modulo_controlador_jogo #(
  parameter int unsigned SHIP_CELLS      = 9,
  parameter int unsigned MAX_SHOTS       = 20,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             button_confirmation,
  input  logic             button_count,
  input  logic             ship_present,
  input  logic             cell_attacked,
  output logic [2:0]       cur_col,
  output logic [2:0]       cur_line,
  output logic [1:0]       preset_sel,
  output logic             po_load,
  output logic             po_clr,
  output logic             at_clr,
  output logic             at_write,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] shots_left,
  output logic [CNT_W-1:0] hits,
  output logic             last_hit,
  output logic             win
);

  // Elaboration-time parameter sanity checks
  if ((2 ** CNT_W) <= MAX_SHOTS) begin : g_chk_cnt_w
    $error("CNT_W too narrow for MAX_SHOTS");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POSITION  = 3'd1,
    S_ATTACK    = 3'd2,
    S_RESOLVE   = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX_SHOTS  = CNT_W'(MAX_SHOTS);
  localparam logic [CNT_W-1:0] LP_SHIP_CELLS = CNT_W'(SHIP_CELLS);
  localparam logic [2:0]       LP_LAST_COL   = 3'd4;
  localparam logic [2:0]       LP_LAST_LINE  = 3'd6;

  // Button path: bit 0 = confirm, bit 1 = count
  logic [1:0] w_btn;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_level;
  logic [1:0] r_prev;
  logic [1:0] w_rise;
  logic       w_conf_evt;
  logic       w_cnt_evt;

  assign w_btn = {button_count, button_confirmation};

  // Two-flop synchronizer for both buttons, released state on reset
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MODULO_CONTROLADOR_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] LP_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_filt;
  logic [DB_W-1:0] r_db_cnt [2];

  // Filtered level follows the synchronized input only after a run of equal samples
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_filt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == LP_DB_LAST) begin
          r_filt[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // Previous-level register for rising-edge detection
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign w_rise     = w_level & ~r_prev;
  assign w_conf_evt = w_rise[0];
  // Confirm wins a same-cycle collision; the count event is dropped
  assign w_cnt_evt  = w_rise[1] & ~w_rise[0];

  // Registered state and datapath
  state_t           r_state;
  logic [2:0]       r_col;
  logic [2:0]       r_line;
  logic [1:0]       r_preset;
  logic             r_po_load;
  logic             r_po_clr;
  logic             r_at_clr;
  logic             r_at_write;
  logic [CNT_W-1:0] r_shots;
  logic [CNT_W-1:0] r_hits;
  logic             r_last;
  logic             r_win;

  // Next-state values
  state_t           w_state_nx;
  logic [2:0]       w_col_nx;
  logic [2:0]       w_line_nx;
  logic [1:0]       w_preset_nx;
  logic             w_po_load_nx;
  logic             w_po_clr_nx;
  logic             w_at_clr_nx;
  logic             w_at_write_nx;
  logic [CNT_W-1:0] w_shots_nx;
  logic [CNT_W-1:0] w_hits_nx;
  logic             w_last_nx;
  logic             w_win_nx;

  // Saturating counter updates applied when a shot resolves
  logic [CNT_W-1:0] w_shots_dec;
  logic [CNT_W-1:0] w_hits_inc;

  assign w_shots_dec = (r_shots != '0) ? (r_shots - 1'b1) : '0;
  assign w_hits_inc  = (r_hits < LP_SHIP_CELLS)
                     ? (r_hits + {{(CNT_W-1){1'b0}}, r_last})
                     : r_hits;

  // FSM state register plus all registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_line     <= '0;
      r_preset   <= '0;
      r_po_load  <= 1'b0;
      r_po_clr   <= 1'b0;
      r_at_clr   <= 1'b0;
      r_at_write <= 1'b0;
      r_shots    <= LP_MAX_SHOTS;
      r_hits     <= '0;
      r_last     <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_col      <= w_col_nx;
      r_line     <= w_line_nx;
      r_preset   <= w_preset_nx;
      r_po_load  <= w_po_load_nx;
      r_po_clr   <= w_po_clr_nx;
      r_at_clr   <= w_at_clr_nx;
      r_at_write <= w_at_write_nx;
      r_shots    <= w_shots_nx;
      r_hits     <= w_hits_nx;
      r_last     <= w_last_nx;
      r_win      <= w_win_nx;
    end
  end

  // Next-state, counter and strobe decisions
  always_comb begin
    w_state_nx    = r_state;
    w_col_nx      = r_col;
    w_line_nx     = r_line;
    w_preset_nx   = r_preset;
    w_po_load_nx  = 1'b0;
    w_po_clr_nx   = 1'b0;
    w_at_clr_nx   = 1'b0;
    w_at_write_nx = 1'b0;
    w_shots_nx    = r_shots;
    w_hits_nx     = r_hits;
    w_last_nx     = r_last;
    w_win_nx      = r_win;

    case (r_state)
      S_IDLE: begin
        if (w_conf_evt) begin
          w_po_clr_nx = 1'b1;
          w_at_clr_nx = 1'b1;
          w_hits_nx   = '0;
          w_shots_nx  = LP_MAX_SHOTS;
          w_last_nx   = 1'b0;
          w_win_nx    = 1'b0;
          w_state_nx  = S_POSITION;
        end
      end

      S_POSITION: begin
        if (w_conf_evt) begin
          w_po_load_nx = 1'b1;
          w_col_nx     = '0;
          w_line_nx    = '0;
          w_state_nx   = S_ATTACK;
        end else if (w_cnt_evt) begin
          w_preset_nx = r_preset + 2'd1;
        end
      end

      S_ATTACK: begin
        if (w_conf_evt) begin
          // at_write is raised here so it is high for the whole RESOLVE cycle
          if (!cell_attacked) begin
            w_last_nx     = ship_present;
            w_at_write_nx = 1'b1;
            w_state_nx    = S_RESOLVE;
          end
        end else if (w_cnt_evt) begin
          if (r_line >= LP_LAST_LINE) begin
            w_line_nx = '0;
            w_col_nx  = (r_col >= LP_LAST_COL) ? 3'd0 : (r_col + 3'd1);
          end else begin
            w_line_nx = r_line + 3'd1;
          end
        end
      end

      S_RESOLVE: begin
        w_shots_nx = w_shots_dec;
        w_hits_nx  = w_hits_inc;
        if (w_hits_inc == LP_SHIP_CELLS) begin
          w_win_nx   = 1'b1;
          w_state_nx = S_GAME_OVER;
        end else if (w_shots_dec == '0) begin
          w_win_nx   = 1'b0;
          w_state_nx = S_GAME_OVER;
        end else begin
          w_state_nx = S_ATTACK;
        end
      end

      S_GAME_OVER: begin
        if (w_conf_evt) begin
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign cur_col    = r_col;
  assign cur_line   = r_line;
  assign preset_sel = r_preset;
  assign po_load    = r_po_load;
  assign po_clr     = r_po_clr;
  assign at_clr     = r_at_clr;
  assign at_write   = r_at_write;
  assign state      = r_state;
  assign shots_left = r_shots;
  assign hits       = r_hits;
  assign last_hit   = r_last;
  assign win        = r_win;

endmodule

// File: tb/tb_modulo_controlador_jogo.sv
// Directed bench for modulo_controlador_jogo (default build, 2-cycle button sync).
module tb_modulo_controlador_jogo;

  logic       clk;
  logic       clr;
  logic       button_confirmation;
  logic       button_count;
  logic       ship_present;
  logic       cell_attacked;
  logic [2:0] cur_col;
  logic [2:0] cur_line;
  logic [1:0] preset_sel;
  logic       po_load;
  logic       po_clr;
  logic       at_clr;
  logic       at_write;
  logic [2:0] state;
  logic [4:0] shots_left;
  logic [4:0] hits;
  logic       last_hit;
  logic       win;

  int total = 0;
  int bad   = 0;

  modulo_controlador_jogo #(
    .SHIP_CELLS(9),
    .MAX_SHOTS(20),
    .CNT_W(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .button_confirmation(button_confirmation),
    .button_count(button_count),
    .ship_present(ship_present),
    .cell_attacked(cell_attacked),
    .cur_col(cur_col),
    .cur_line(cur_line),
    .preset_sel(preset_sel),
    .po_load(po_load),
    .po_clr(po_clr),
    .at_clr(at_clr),
    .at_write(at_write),
    .state(state),
    .shots_left(shots_left),
    .hits(hits),
    .last_hit(last_hit),
    .win(win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise buttons and stop #1 after the edge where the FSM reacts
  task automatic push(input logic c, input logic n);
    button_confirmation = c;
    button_count        = n;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Release buttons and let the synchronizer and edge register settle
  task automatic rel();
    button_confirmation = 1'b0;
    button_count        = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic counts(input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b0, 1'b1);
      rel();
    end
  endtask

  task automatic confirm();
    push(1'b1, 1'b0);
    rel();
  endtask

  // One unattacked shot: ATTACK -> RESOLVE -> next state
  task automatic shot(input logic hit);
    ship_present  = hit;
    cell_attacked = 1'b0;
    push(1'b1, 1'b0);
    @(posedge clk);
    #1;
    rel();
  endtask

  task automatic check_cursor(input string tag, input logic [2:0] c, input logic [2:0] l);
    chk({tag, "_col"}, 32'(cur_col), 32'(c));
    chk({tag, "_line"}, 32'(cur_line), 32'(l));
  endtask

  initial begin
    clr                 = 1'b0;
    button_confirmation = 1'b0;
    button_count        = 1'b0;
    ship_present        = 1'b0;
    cell_attacked       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_shots", 32'(shots_left), 32'd20);
    chk("rst_hits", 32'(hits), 32'd0);
    chk("rst_strobes", 32'({po_load, po_clr, at_clr, at_write}), 32'd0);
    chk("rst_flags", 32'({last_hit, win, preset_sel}), 32'd0);
    check_cursor("rst", 3'd0, 3'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;

    // IDLE confirm: clear strobes for exactly one cycle
    push(1'b1, 1'b0);
    chk("idle_po_clr", 32'(po_clr), 32'd1);
    chk("idle_at_clr", 32'(at_clr), 32'd1);
    chk("idle_to_pos", 32'(state), 32'd1);
    @(posedge clk);
    #1;
    chk("idle_po_clr_drop", 32'(po_clr), 32'd0);
    chk("idle_at_clr_drop", 32'(at_clr), 32'd0);
    rel();

    // Preset selection wraps modulo 4
    counts(5);
    chk("preset_5", 32'(preset_sel), 32'd1);

    // POSITION confirm: load strobe, enter ATTACK at (0,0)
    push(1'b1, 1'b0);
    chk("pos_po_load", 32'(po_load), 32'd1);
    chk("pos_to_atk", 32'(state), 32'd2);
    check_cursor("pos", 3'd0, 3'd0);
    @(posedge clk);
    #1;
    chk("pos_po_load_drop", 32'(po_load), 32'd0);
    rel();

    // Cursor walk and wrap
    counts(34);
    check_cursor("cur34", 3'd4, 3'd6);
    counts(1);
    check_cursor("cur_wrap", 3'd0, 3'd0);
    counts(7);
    check_cursor("cur_col1", 3'd1, 3'd0);
    button_count = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rel();
    check_cursor("cur_hold", 3'd1, 3'd1);

    // First shot is a hit
    ship_present  = 1'b1;
    cell_attacked = 1'b0;
    push(1'b1, 1'b0);
    chk("hit_resolve_state", 32'(state), 32'd3);
    chk("hit_at_write", 32'(at_write), 32'd1);
    chk("hit_last_hit", 32'(last_hit), 32'd1);
    @(posedge clk);
    #1;
    chk("hit_back_attack", 32'(state), 32'd2);
    chk("hit_at_write_drop", 32'(at_write), 32'd0);
    chk("hit_hits", 32'(hits), 32'd1);
    chk("hit_shots", 32'(shots_left), 32'd19);
    rel();
    check_cursor("hit_cursor", 3'd1, 3'd1);

    // Confirm on an already attacked cell is ignored
    cell_attacked = 1'b1;
    push(1'b1, 1'b0);
    chk("dup_state", 32'(state), 32'd2);
    chk("dup_at_write", 32'(at_write), 32'd0);
    rel();
    chk("dup_hits", 32'(hits), 32'd1);
    chk("dup_shots", 32'(shots_left), 32'd19);

    // Confirm and count together: confirm wins, cursor stays
    ship_present  = 1'b0;
    cell_attacked = 1'b0;
    push(1'b1, 1'b1);
    chk("both_state", 32'(state), 32'd3);
    check_cursor("both", 3'd1, 3'd1);
    @(posedge clk);
    #1;
    rel();
    chk("both_shots", 32'(shots_left), 32'd18);
    chk("both_last_hit", 32'(last_hit), 32'd0);
    check_cursor("both_after", 3'd1, 3'd1);

    // Finish game 1 with misses: loss with one hit
    for (int i = 0; i < 17; i++) shot(1'b0);
    chk("g1_shots1_state", 32'(state), 32'd2);
    chk("g1_shots1", 32'(shots_left), 32'd1);
    shot(1'b0);
    chk("g1_over_state", 32'(state), 32'd4);
    chk("g1_win", 32'(win), 32'd0);
    chk("g1_hits", 32'(hits), 32'd1);
    chk("g1_shots0", 32'(shots_left), 32'd0);

    // GAME_OVER ignores count and shot attempts
    counts(1);
    chk("go_count_state", 32'(state), 32'd4);
    check_cursor("go_count", 3'd1, 3'd1);

    // GAME_OVER confirm returns to IDLE with counters retained
    confirm();
    chk("go_to_idle", 32'(state), 32'd0);
    chk("idle_keep_hits", 32'(hits), 32'd1);
    chk("idle_keep_shots", 32'(shots_left), 32'd0);
    confirm();
    chk("g2_pos", 32'(state), 32'd1);
    chk("g2_shots", 32'(shots_left), 32'd20);
    chk("g2_hits", 32'(hits), 32'd0);
    chk("g2_preset", 32'(preset_sel), 32'd1);
    confirm();
    chk("g2_atk", 32'(state), 32'd2);
    check_cursor("g2", 3'd0, 3'd0);

    // Game 2: 11 misses then 9 hits, the last hit on the final shot
    for (int i = 0; i < 11; i++) shot(1'b0);
    chk("g2_misses_shots", 32'(shots_left), 32'd9);
    for (int i = 0; i < 8; i++) shot(1'b1);
    chk("g2_pre_state", 32'(state), 32'd2);
    chk("g2_pre_hits", 32'(hits), 32'd8);
    chk("g2_pre_shots", 32'(shots_left), 32'd1);
    shot(1'b1);
    chk("g2_over_state", 32'(state), 32'd4);
    chk("g2_win", 32'(win), 32'd1);
    chk("g2_hits9", 32'(hits), 32'd9);
    chk("g2_shots0", 32'(shots_left), 32'd0);

    // Game 3: all misses
    confirm();
    confirm();
    confirm();
    chk("g3_atk", 32'(state), 32'd2);
    for (int i = 0; i < 20; i++) shot(1'b0);
    chk("g3_over_state", 32'(state), 32'd4);
    chk("g3_win", 32'(win), 32'd0);
    chk("g3_hits", 32'(hits), 32'd0);
    chk("g3_shots", 32'(shots_left), 32'd0);

    // Reset while at_write is high
    confirm();
    confirm();
    confirm();
    counts(1);
    check_cursor("g4_move", 3'd0, 3'd1);
    ship_present  = 1'b1;
    cell_attacked = 1'b0;
    push(1'b1, 1'b0);
    chk("rr_at_write", 32'(at_write), 32'd1);
    chk("rr_state3", 32'(state), 32'd3);
    #2;
    clr = 1'b0;
    #1;
    chk("rr_at_write_drop", 32'(at_write), 32'd0);
    chk("rr_state", 32'(state), 32'd0);
    chk("rr_shots", 32'(shots_left), 32'd20);
    chk("rr_hits", 32'(hits), 32'd0);
    chk("rr_last_hit", 32'(last_hit), 32'd0);
    check_cursor("rr", 3'd0, 3'd0);
    button_confirmation = 1'b0;
    button_count        = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
